muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 121 ++++++++++++
 tb/tb_muldiv_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply / restoring divide sequencer, one bit per clock.
// Handshake: ready/start in, done pulse out with result, remainder and destination tag.
module muldiv_seq #(
   parameter int RV = 32,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_mul,
   input  logic          start_div,
   input  logic          kill,
   input  logic [RV-1:0] rs1_val,
   input  logic [RV-1:0] rs2_val,
   input  logic [3:0]    rd_in,
   output logic          ready,
   output logic          busy,
   output logic          done,
   output logic [RV-1:0] result,
   output logic [RV-1:0] rem,
   output logic [3:0]    rd_out,
   output logic          div_zero
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t        r_state;
   logic [RV-1:0] r_opa;    // multiplicand, or dividend shifting into quotient
   logic [RV-1:0] r_opb;    // multiplier, or divisor
   logic [RV-1:0] r_acc;    // product accumulator, or partial remainder
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_rd;

   logic          w_accept;
   logic          w_last;
   logic [RV-1:0] w_mul_acc;
   logic [RV:0]   w_shift;
   logic          w_ge;
   logic [RV-1:0] w_sub_lo;
   logic [RV-1:0] w_rem_nx;
   logic [RV-1:0] w_quo_nx;

   assign ready = (r_state == IDLE) || (r_state == DONE);
   assign busy  = (r_state == MUL) || (r_state == DIV);
   assign done  = (r_state == DONE);

   assign w_accept  = ready && !kill && (start_mul || start_div);
   assign w_last    = (r_cnt == CW'(RV - 1));
   assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);

   // The remainder after each step is below the divisor, so RV bits hold it.
   assign w_shift  = {r_acc, r_opa[RV-1]};
   assign w_ge     = (w_shift >= {1'b0, r_opb});
   assign w_sub_lo = w_shift[RV-1:0] - r_opb;
   assign w_rem_nx = w_ge ? w_sub_lo : w_shift[RV-1:0];
   assign w_quo_nx = {r_opa[RV-2:0], w_ge};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_opa    <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_rd     <= '0;
         result   <= '0;
         rem      <= '0;
         rd_out   <= '0;
         div_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_opa   <= rs1_val;
                  r_opb   <= rs2_val;
                  r_rd    <= rd_in;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= start_mul ? MUL : DIV;
               end else begin
                  r_state <= IDLE;
               end
            end
            MUL: begin
               if (kill) begin
                  r_state <= IDLE;
               end else begin
                  r_acc <= w_mul_acc;
                  r_opa <= r_opa << 1;
                  r_opb <= r_opb >> 1;
                  r_cnt <= r_cnt + CW'(1);
                  if (w_last) begin
                     result   <= w_mul_acc;
                     rem      <= '0;
                     rd_out   <= r_rd;
                     div_zero <= 1'b0;
                     r_state  <= DONE;
                  end
               end
            end
            DIV: begin
               if (kill) begin
                  r_state <= IDLE;
               end else begin
                  r_acc <= w_rem_nx;
                  r_opa <= w_quo_nx;
                  r_cnt <= r_cnt + CW'(1);
                  if (w_last) begin
                     result   <= w_quo_nx;
                     rem      <= w_rem_nx;
                     rd_out   <= r_rd;
                     div_zero <= (r_opb == '0);
                     r_state  <= DONE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at RV=16.
module tb_muldiv_seq;

   localparam int RV = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_mul, start_div, kill;
   logic [RV-1:0] rs1_val, rs2_val;
   logic [3:0]    rd_in;
   logic          ready, busy, done, div_zero;
   logic [RV-1:0] result, rem;
   logic [3:0]    rd_out;

   int checks = 0;
   int errors = 0;
   int n;
   logic seen_done;

   muldiv_seq #(.RV(RV), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start_mul(start_mul), .start_div(start_div),
      .kill(kill), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
      .ready(ready), .busy(busy), .done(done), .result(result), .rem(rem),
      .rd_out(rd_out), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic d, input logic [RV-1:0] a,
                        input logic [RV-1:0] b, input logic [3:0] rd);
      start_mul = m; start_div = d; rs1_val = a; rs2_val = b; rd_in = rd;
      tick();
      start_mul = 1'b0; start_div = 1'b0;
      rs1_val = '0; rs2_val = '0; rd_in = '0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b0; start_mul = 0; start_div = 0; kill = 0;
      rs1_val = '0; rs2_val = '0; rd_in = '0;
      #2;
      chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_result", result, 0); chk("rst_rem", rem, 0);
      chk("rst_rd", rd_out, 0); chk("rst_dz", div_zero, 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // multiply 0x0123 * 0x0045
      issue(1, 0, 16'h0123, 16'h0045, 4'd9);
      chk("mul_busy", busy, 1); chk("mul_ready", ready, 0);
      wait_done(n);
      chk("mul_lat", n, 16);
      chk("mul_done", done, 1); chk("mul_res", result, 16'h4E6F);
      chk("mul_rem", rem, 0); chk("mul_rd", rd_out, 9); chk("mul_rdy_done", ready, 1);
      tick();
      chk("mul_pulse", done, 0); chk("mul_idle", ready, 1); chk("mul_hold", result, 16'h4E6F);

      // divide 1000 / 7
      issue(0, 1, 16'd1000, 16'd7, 4'd3);
      wait_done(n);
      chk("div_lat", n, 16);
      chk("div_res", result, 142); chk("div_rem", rem, 6);
      chk("div_dz", div_zero, 0); chk("div_rd", rd_out, 3);
      tick();

      // divide by zero
      issue(0, 1, 16'h1234, 16'h0000, 4'd4);
      wait_done(n);
      chk("dz_res", result, 16'hFFFF); chk("dz_rem", rem, 16'h1234);
      chk("dz_flag", div_zero, 1);
      tick();

      // wrap multiply, then back-to-back divide from the DONE cycle
      issue(1, 0, 16'hFFFF, 16'hFFFF, 4'd5);
      wait_done(n);
      chk("wrap_res", result, 16'h0001); chk("wrap_dz", div_zero, 0);
      issue(0, 1, 16'd100, 16'd9, 4'd7);
      chk("b2b_busy", busy, 1); chk("b2b_done", done, 0);
      wait_done(n);
      chk("b2b_lat", n + 1, 17);
      chk("b2b_res", result, 11); chk("b2b_rem", rem, 1); chk("b2b_rd", rd_out, 7);
      tick();

      // kill during multiply iteration 8
      issue(1, 0, 16'd3, 16'd4, 4'd2);
      repeat (7) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kill_ready", ready, 1); chk("kill_busy", busy, 0); chk("kill_done", done, 0);
      seen_done = 1'b0;
      repeat (20) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      chk("kill_nodone", seen_done, 0);
      chk("kill_res", result, 11); chk("kill_rd", rd_out, 7);

      // asynchronous reset mid-divide
      issue(0, 1, 16'd500, 16'd3, 4'd6);
      repeat (5) tick();
      #2 reset = 1'b0;
      #1;
      chk("arst_res", result, 0); chk("arst_rem", rem, 0); chk("arst_rd", rd_out, 0);
      chk("arst_ready", ready, 1); chk("arst_busy", busy, 0);
      tick();
      reset = 1'b1;
      tick();

      // both starts: multiply wins
      issue(1, 1, 16'd6, 16'd7, 4'd1);
      wait_done(n);
      chk("both_lat", n, 16);
      chk("both_res", result, 42); chk("both_rem", rem, 0); chk("both_rd", rd_out, 1);
      tick();

      // start with kill high is ignored
      kill = 1'b1;
      issue(1, 0, 16'd2, 16'd2, 4'd8);
      kill = 1'b0;
      chk("ks_busy", busy, 0); chk("ks_ready", ready, 1);
      seen_done = 1'b0;
      repeat (20) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      chk("ks_nodone", seen_done, 0); chk("ks_res", result, 42);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
